wb_arb_mux: RTL and testbench
=============================

Name: wb_arb_mux

Overview:
- Parametrised N-way registered arbitrating multiplexer. It is the successor to the plain 32-bit two-input select mux.
- It merges NUM_IN valid/ready source channels (execute units, load unit, CSR unit) onto one registered writeback channel.
- Round-robin fairness and a single output pipeline register give one-cycle latency with full throughput.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), localparam (not overridable); width of the source index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed source data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, last-grant pointer=NUM_IN-1, so channel 0 has first priority after reset.
- load = !out_valid | out_ready. The output register accepts new data only when load is high.
- Arbitration (combinational):
  - Search in_valid starting at index (pointer+1) mod NUM_IN, wrapping around; the first set bit is the grant.
  - At most one grant bit is set.
  - No valid input means no grant.
- in_ready[i] = load & grant[i]. in_ready is never asserted for a channel with in_valid low.
- Transfer in: on a clock edge with load and any grant:
  - out_data <= granted channel data.
  - out_src <= granted index.
  - out_valid <= 1.
  - pointer <= granted index.
- Transfer out: on a clock edge with out_valid & out_ready and no grant: out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous out and in (out_valid & out_ready & grant): the register reloads in the same cycle. This sustains one transfer per cycle, with no bubble.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid hold. All in_ready stay 0. The pointer holds.
- Latency: a transfer on input edge N gives out_valid high after edge N, for exactly one cycle if out_ready is high.
- Sources may drop in_valid without a handshake. Arbitration re-evaluates every cycle; there is no grant lock.
- Fairness: with all channels continuously valid and out_ready=1, the grant sequence is 0,1,...,NUM_IN-1,0,...
- Reset asserted mid-stall: the held output is discarded and out_valid=0 immediately. No in_ready pulse occurs while rst_n is low.
- No width conversion: out_data is a bit-exact copy of the selected channel.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: the pointer logic is removed. Grant = lowest-index valid channel, so channel 0 always wins. All handshake, register and stall rules are unchanged.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Reset with all in_valid=1 and out_ready=1 -> out_valid=0 during reset. After release, out_src sequence is 0,1,2,3,0 on consecutive cycles, and out_data matches channel data 0xA0,0xA1,0xA2,0xA3,0xA0.
2. Only channel 2 valid with data 0xDEADBEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2. in_valid drops -> out_valid=0 the following cycle.
3. Stall: out_ready=0 for 5 cycles with channels 1 and 3 valid -> out_data/out_src held, in_ready=0 throughout. out_ready=1 -> one transfer per cycle resumes with the pointer order preserved.
4. Back-to-back: channel 0 valid continuously, others idle, out_ready=1 -> out_valid stays 1 with data updating every cycle and no bubble.
5. Assert rst_n=0 asynchronously mid-stall with out_valid=1 -> out_valid=0 before the next clock edge. After release, channel 0 is granted first.
6. With WB_ARB_FIXED_PRIO_EN defined and all channels valid -> out_src=0 every cycle; channel 3 is granted only when channels 0-2 are idle.

Source files
------------

// File: rtl/wb_arb_mux.sv
// wb_arb_mux: N-way registered arbitrating multiplexer with valid/ready
// handshakes on every side. It merges NUM_IN source channels onto one
// registered writeback channel, with one-cycle latency and full throughput.
// Optional macro WB_ARB_FIXED_PRIO_EN: when defined, arbitration becomes fixed
// priority (the lowest-index valid channel wins) and the round-robin pointer
// is removed.
module wb_arb_mux #(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic              load;
   logic              any_grant;
   logic [SEL_W-1:0]  gnt_idx;
   logic [NUM_IN-1:0] grant;

`ifndef WB_ARB_FIXED_PRIO_EN
   logic [SEL_W-1:0]  ptr;
`endif

   // load is gated by rst_n so that no in_ready pulse can appear during reset
   assign load     = rst_n & (~out_valid | out_ready);
   assign grant    = any_grant ? (NUM_IN'(1) << gnt_idx) : '0;
   assign in_ready = grant & {NUM_IN{load}};

   // Grant search: the first valid channel found in search order wins
   always_comb begin
      int unsigned idx;
      any_grant = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = (32'(ptr) + 1 + k) % NUM_IN;
`endif
         if (!any_grant && in_valid[idx]) begin
            any_grant = 1'b1;
            gnt_idx   = SEL_W'(idx);
         end
      end
   end

   // Output register: reload on any grant, otherwise drain; hold during a stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (load) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= in_data[32'(gnt_idx)*WIDTH +: WIDTH];
            out_src   <= gnt_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   // Last-grant pointer: reset to NUM_IN-1 so that channel 0 has first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= SEL_W'(NUM_IN - 1);
      end else if (load && any_grant) begin
         ptr <= gnt_idx;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arb_mux.sv
// Directed self-checking bench for wb_arb_mux (WIDTH=32, NUM_IN=4).
// Inputs change on the falling edge and outputs are checked there as well,
// well away from the rising edge on which the DUT captures data.
module tb_wb_arb_mux;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   int asserts = 0;
   int fails   = 0;

   wb_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [1:0] exp_src [5];
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 4'hF;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
      repeat (3) begin
         @(negedge clk);
         asserts++;
         if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%b, required 0/0000", out_valid, in_ready);
         end
      end
      asserts++;
      if (out_data !== 32'h0 || out_src !== 2'd0) begin
         fails++;
         $display("FAIL reset_values: out_data=%h out_src=%0d, required 0/0", out_data, out_src);
      end
      rst_n = 1'b1;
      #1;
      asserts++;
      if (in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL reset_first_grant: in_ready=%b, required 0001", in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         asserts++;
         if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== (32'hA0 + 32'(exp_src[i]))) begin
            fails++;
            $display("FAIL rr_sequence[%0d]: valid=%b src=%0d data=%h, required 1/%0d/%h",
                     i, out_valid, out_src, out_data, exp_src[i], 32'hA0 + 32'(exp_src[i]));
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      in_data[2*32 +: 32] = 32'hDEADBEEF;
      in_valid = 4'b0100;
      #1;
      asserts++;
      if (in_ready !== 4'b0100) begin
         fails++;
         $display("FAIL single_ready: in_ready=%b, required 0100", in_ready);
      end
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 2'd2) begin
         fails++;
         $display("FAIL single_out: valid=%b data=%h src=%0d, required 1/deadbeef/2", out_valid, out_data, out_src);
      end
      in_valid = 4'b0000;
      #1;
      asserts++;
      if (in_ready !== 4'b0000) begin
         fails++;
         $display("FAIL single_idle_ready: in_ready=%b, required 0000", in_ready);
      end
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF || out_src !== 2'd2) begin
         fails++;
         $display("FAIL single_drain: valid=%b data=%h src=%0d, required 0/deadbeef/2", out_valid, out_data, out_src);
      end
   endtask

   task automatic test_stall();
      logic [1:0] exp_src [3];
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_src = '{2'd1, 2'd1, 2'd1};
`else
      exp_src = '{2'd3, 2'd1, 2'd3};
`endif
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hB0 + i;
      in_valid = 4'b1010;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         asserts++;
         if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 32'hB1 || in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL stall_hold[%0d]: valid=%b src=%0d data=%h in_ready=%b, required 1/1/b1/0000",
                     i, out_valid, out_src, out_data, in_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         asserts++;
         if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== (32'hB0 + 32'(exp_src[i]))) begin
            fails++;
            $display("FAIL stall_resume[%0d]: valid=%b src=%0d data=%h, required 1/%0d/%h",
                     i, out_valid, out_src, out_data, exp_src[i], 32'hB0 + 32'(exp_src[i]));
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      in_data[0 +: 32] = 32'h100;
      in_valid = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         asserts++;
         if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== (32'h100 + 32'(k - 1))) begin
            fails++;
            $display("FAIL back_to_back[%0d]: valid=%b src=%0d data=%h, required 1/0/%h",
                     k, out_valid, out_src, out_data, 32'h100 + 32'(k - 1));
         end
         in_data[0 +: 32] = 32'h100 + 32'(k);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      in_data[1*32 +: 32] = 32'hC1;
      in_valid = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b1 || out_data !== 32'hC1) begin
         fails++;
         $display("FAIL areset_pre: valid=%b data=%h, required 1/c1", out_valid, out_data);
      end
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hD0 + i;
      #2 rst_n = 1'b0;
      #1;
      asserts++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 4'b0000) begin
         fails++;
         $display("FAIL areset_now: valid=%b data=%h in_ready=%b, required 0/0/0000", out_valid, out_data, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      asserts++;
      if (in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL areset_ready: in_ready=%b, required 0001", in_ready);
      end
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hD0) begin
         fails++;
         $display("FAIL areset_first: valid=%b src=%0d data=%h, required 1/0/d0", out_valid, out_src, out_data);
      end
   endtask

   task automatic test_fixed_prio();
      logic [1:0] exp_src [3];
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_src = '{2'd3, 2'd0, 2'd0};
`else
      exp_src = '{2'd3, 2'd0, 2'd1};
`endif
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hE0 + i;
      in_valid = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 4'hF;
         asserts++;
         if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== (32'hE0 + 32'(exp_src[i]))) begin
            fails++;
            $display("FAIL prio[%0d]: valid=%b src=%0d data=%h, required 1/%0d/%h",
                     i, out_valid, out_src, out_data, exp_src[i], 32'hE0 + 32'(exp_src[i]));
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_async_reset();
      test_fixed_prio();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
